// File: rtl/priority_drain.sv
// Loads a 16-bit request vector and drains it one index per handshake, highest bit first.
// Build option: define PRIORITY_DRAIN_MERGE_EN to accept OR-merge loads while draining.
module priority_drain #(
    parameter logic [7:0] NONE_CODE = 8'hF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_a,
    input  logic [7:0]  load_b,
    output logic        code_valid,
    input  logic        code_ready,
    output logic [7:0]  code,
    output logic [15:0] pending,
    output logic [4:0]  count,
    output logic        done
);

`ifdef PRIORITY_DRAIN_MERGE_EN
    localparam bit LP_MERGE = 1'b1;
`else
    localparam bit LP_MERGE = 1'b0;
`endif

    // Handshakes: a load happens when load_valid && load_ready at a rising edge;
    // a code transfers when code_valid && code_ready at a rising edge.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_load_ready;
    logic        r_code_valid;
    logic [7:0]  r_code;
    logic [15:0] r_pending;
    logic [4:0]  r_count;
    logic        r_done;

    logic [15:0] w_new;
    logic        w_load;
    logic        w_xfer;
    logic        w_is_none;
    logic        w_merge;
    logic [15:0] w_clr;
    logic [15:0] w_pend_next;

    function automatic logic [3:0] f_top_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (v[k]) idx = 4'(k);
        end
        return idx;
    endfunction

    function automatic logic [7:0] f_code(input logic [15:0] v);
        return (v == 16'd0) ? NONE_CODE : {4'b0000, f_top_idx(v)};
    endfunction

    always_comb begin
        w_new       = {load_a, load_b};
        w_load      = load_valid & r_load_ready;
        w_xfer      = r_code_valid & code_ready;
        w_is_none   = (r_code == NONE_CODE);
        w_merge     = LP_MERGE & w_load & (r_state == EMIT);
        w_clr       = 16'd0;
        if (w_xfer && !w_is_none) w_clr[r_code[3:0]] = 1'b1;
        // A re-requested bit survives its own transfer because the merge is ORed after the clear.
        w_pend_next = (r_pending & ~w_clr) | (w_merge ? w_new : 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_load_ready <= 1'b0;
            r_code_valid <= 1'b0;
            r_code       <= 8'h00;
            r_pending    <= 16'd0;
            r_count      <= 5'd0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_load_ready <= 1'b1;
                    if (w_load) begin
                        r_state      <= EMIT;
                        r_pending    <= w_new;
                        r_count      <= 5'd0;
                        r_code_valid <= 1'b1;
                        r_code       <= f_code(w_new);
                        r_load_ready <= LP_MERGE;
                    end
                end
                EMIT: begin
                    r_pending <= w_pend_next;
                    // The presented code only moves on a transfer, so merges show up on the next code.
                    if (w_xfer) begin
                        if (!w_is_none) r_count <= r_count + 5'd1;
                        if (w_pend_next == 16'd0) begin
                            r_state      <= IDLE;
                            r_code_valid <= 1'b0;
                            r_code       <= 8'h00;
                            r_done       <= 1'b1;
                            r_load_ready <= 1'b1;
                        end else begin
                            r_code <= f_code(w_pend_next);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign code_valid = r_code_valid;
    assign code       = r_code;
    assign pending    = r_pending;
    assign count      = r_count;
    assign done       = r_done;

endmodule

// File: tb/tb_priority_drain.sv
// Self-checking bench for priority_drain: vector table, corner sequences, randomized batches.
module tb_priority_drain;

    localparam logic [7:0] NONE = 8'hF0;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_a;
    logic [7:0]  load_b;
    logic        code_valid;
    logic        code_ready;
    logic [7:0]  code;
    logic [15:0] pending;
    logic [4:0]  count;
    logic        done;

    int checks   = 0;
    int failures = 0;

    priority_drain #(.NONE_CODE(NONE)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_a     (load_a),
        .load_b     (load_b),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .pending    (pending),
        .count      (count),
        .done       (done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns just after the falling edge following the load.
    task automatic do_load(input logic [15:0] vec);
        int n;
        n = 0;
        load_valid = 1'b1;
        {load_a, load_b} = vec;
        while (!load_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("load_accept_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        load_a = 8'h00;
        load_b = 8'h00;
    endtask

    // Loads vec, drains it with code_ready asserted rdy_pct% of cycles, checks against the model.
    task automatic drain(input logic [15:0] vec, input int rdy_pct,
                         output logic [7:0] first_code, output logic [4:0] final_count);
        logic [7:0]  exp_q[$];
        logic [15:0] exp_pend;
        int          exp_cnt;
        int          n_codes;
        int          cycles;
        exp_q.delete();
        if (vec == 16'd0) exp_q.push_back(NONE);
        else for (int i = 15; i >= 0; i--) if (vec[i]) exp_q.push_back(8'(i));
        n_codes  = exp_q.size();
        exp_cnt  = (vec == 16'd0) ? 0 : n_codes;
        exp_pend = vec;
        do_load(vec);
        first_code = code;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 400) begin
            chk("drain_valid", 32'(code_valid), 32'd1);
            chk("drain_code", 32'(code), 32'(exp_q[0]));
            chk("drain_pending", 32'(pending), 32'(exp_pend));
            chk("drain_no_early_done", 32'(done), 32'd0);
            code_ready = ($urandom_range(99) < rdy_pct) ? 1'b1 : 1'b0;
            if (code_ready) begin
                if (exp_q[0] != NONE) exp_pend[exp_q[0][3:0]] = 1'b0;
                void'(exp_q.pop_front());
            end
            @(negedge clk);
            cycles++;
        end
        code_ready = 1'b0;
        chk("drain_timeout", 32'(cycles < 400), 32'd1);
        if (rdy_pct >= 100) chk("drain_throughput", 32'(cycles), 32'(n_codes));
        chk("end_done", 32'(done), 32'd1);
        chk("end_valid", 32'(code_valid), 32'd0);
        chk("end_code_zero", 32'(code), 32'd0);
        chk("end_count", 32'(count), 32'(exp_cnt));
        chk("end_load_ready", 32'(load_ready), 32'd1);
        final_count = count;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("count_holds", 32'(count), 32'(exp_cnt));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_first;
        logic [4:0] exp_count;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0]  fc;
        logic [4:0]  fcnt;
        logic [15:0] rv;
        int          w;

        tbl[0] = '{8'h80, 8'h01, 8'h0F, 5'd2};
        tbl[1] = '{8'h00, 8'h00, 8'hF0, 5'd0};
        tbl[2] = '{8'h24, 8'h00, 8'h0D, 5'd2};
        tbl[3] = '{8'hFF, 8'hFF, 8'h0F, 5'd16};
        tbl[4] = '{8'h00, 8'h01, 8'h00, 5'd1};
        tbl[5] = '{8'h01, 8'h80, 8'h08, 5'd2};

        rst = 1'b1;
        load_valid = 1'b0;
        load_a = 8'h00;
        load_b = 8'h00;
        code_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_code_valid", 32'(code_valid), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        #1 chk("rst_release_ready_low", 32'(load_ready), 32'd0);
        @(negedge clk);
        chk("rst_release_ready_high", 32'(load_ready), 32'd1);

        // Table vectors, full-rate drain
        for (int t = 0; t < 6; t++) begin
            drain({tbl[t].a, tbl[t].b}, 100, fc, fcnt);
            chk("tbl_first_code", 32'(fc), 32'(tbl[t].exp_first));
            chk("tbl_count", 32'(fcnt), 32'(tbl[t].exp_count));
        end

        // Backpressure: code and pending hold while code_ready is low
        do_load(16'h2400);
        for (int i = 0; i < 5; i++) begin
            chk("hold_code", 32'(code), 32'h0D);
            chk("hold_pending", 32'(pending), 32'h2400);
            chk("hold_valid", 32'(code_valid), 32'd1);
            @(negedge clk);
        end
        code_ready = 1'b1;
        chk("release_code0", 32'(code), 32'h0D);
        @(negedge clk);
        chk("release_code1", 32'(code), 32'h0A);
        chk("release_pending", 32'(pending), 32'h0400);
        @(negedge clk);
        code_ready = 1'b0;
        chk("release_done", 32'(done), 32'd1);
        chk("release_count", 32'(count), 32'd2);
        @(negedge clk);

        // Reset mid-batch discards it, asynchronously, with no done pulse
        do_load(16'h8000);
        chk("midrst_code_before", 32'(code), 32'h0F);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(code_valid), 32'd0);
        chk("midrst_code", 32'(code), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_load_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        chk("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_back", 32'(load_ready), 32'd1);
        chk("midrst_no_done", 32'(done), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);

`ifdef PRIORITY_DRAIN_MERGE_EN
        // Merge load in the same cycle index 1 transfers
        do_load(16'h0003);
        chk("merge_first", 32'(code), 32'h01);
        chk("merge_ready_in_emit", 32'(load_ready), 32'd1);
        code_ready = 1'b1;
        load_valid = 1'b1;
        {load_a, load_b} = 16'h8002;
        @(negedge clk);
        load_valid = 1'b0;
        chk("merge_code_f", 32'(code), 32'h0F);
        chk("merge_pending", 32'(pending), 32'h8003);
        @(negedge clk);
        chk("merge_code_1", 32'(code), 32'h01);
        @(negedge clk);
        chk("merge_code_0", 32'(code), 32'h00);
        @(negedge clk);
        code_ready = 1'b0;
        chk("merge_done", 32'(done), 32'd1);
        chk("merge_count", 32'(count), 32'd4);
        @(negedge clk);
`else
        // Loads offered during EMIT are refused until the batch ends
        do_load(16'h0100);
        load_valid = 1'b1;
        {load_a, load_b} = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            chk("nomerge_ready_low", 32'(load_ready), 32'd0);
            chk("nomerge_pending", 32'(pending), 32'h0100);
            chk("nomerge_code", 32'(code), 32'h08);
            @(negedge clk);
        end
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        chk("nomerge_done", 32'(done), 32'd1);
        chk("nomerge_ready_idle", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("nomerge_late_load", 32'(pending), 32'hFFFF);
        chk("nomerge_late_code", 32'(code), 32'h0F);
        code_ready = 1'b1;
        w = 0;
        while (code_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        code_ready = 1'b0;
        chk("nomerge_drain_timeout", 32'(w < 40), 32'd1);
        @(negedge clk);
`endif

        // Randomized batches against the model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(3))
                0: rv = 16'd0;
                1: rv = 16'd1 << $urandom_range(15);
                2: begin rv = 16'($urandom); rv = rv & 16'($urandom); end
                default: rv = 16'($urandom);
            endcase
            drain(rv, $urandom_range(100, 30), fc, fcnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priority_drain.md
PRIORITY_DRAIN -- requirements
Module: priority_drain

Interface
REQ-001 Parameter: NONE_CODE, 8'hF0, code emitted once for an all-zero loaded vector.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: load_valid  in  1  upstream offers a request vector.
REQ-005 Port: load_ready  out  1  block accepts a vector; load occurs when load_valid and load_ready are both high at a rising edge.
REQ-006 Port: load_a  in  8  request bits 15:8 of the vector.
REQ-007 Port: load_b  in  8  request bits 7:0 of the vector.
REQ-008 Port: code_valid  out  1  code holds a valid index.
REQ-009 Port: code_ready  in  1  downstream accepts code; transfer occurs when code_valid and code_ready are both high at a rising edge.
REQ-010 Port: code  out  8  index 0..15 of the highest pending bit in 8'b0000_iiii form, or NONE_CODE.
REQ-011 Port: pending  out  16  registered vector of not-yet-emitted requests.
REQ-012 Port: count  out  5  number of codes transferred since the last load from IDLE (0..16).
REQ-013 Port: done  out  1  one-cycle pulse in the cycle after the final code of a batch transfers.

Function
REQ-014 FSM states SHALL be IDLE and EMIT only.
REQ-015 IDLE: load_ready=1, code_valid=0; on load, pending<={load_a,load_b}, count<=0, next state EMIT.
REQ-016 EMIT: code_valid=1; code SHALL equal the index of the highest set bit of pending (bit 15 highest priority); if pending==0 at entry, code=NONE_CODE.
REQ-017 Latency: code_valid SHALL rise in the cycle after the load cycle; no combinational path from load_* to code*.
REQ-018 code SHALL remain stable while code_valid=1 and code_ready=0.
REQ-019 On a transfer of index i, bit i of pending SHALL clear and count SHALL increment; the next code SHALL be presented the following cycle (throughput one code per cycle).
REQ-020 Transfer of the last set bit, or of NONE_CODE, SHALL return the FSM to IDLE and pulse done for exactly one cycle; count SHALL hold its final value until the next load.
REQ-021 A NONE_CODE transfer SHALL NOT increment count.
REQ-022 code SHALL be 8'h00 whenever code_valid=0.

Reset
REQ-023 While rst=1, independent of clk: state=IDLE, pending=0, count=0, code=8'h00, code_valid=0, done=0, load_ready=0.
REQ-024 load_ready SHALL go to 1 on the first rising edge after rst deasserts; assertion mid-batch SHALL discard the batch, with no done pulse.

Configuration
REQ-025 Macro PRIORITY_DRAIN_MERGE_EN defined: load_ready=1 in EMIT as well; a load in EMIT ORs {load_a,load_b} into pending without resetting count, and takes effect on the next presented code.
REQ-026 If a merge load and a transfer of index i occur in the same cycle, pending<=(pending & ~(1<<i)) | new; a re-requested bit i SHALL stay set.
REQ-027 A merge load that arrives in the same cycle as the batch's final transfer SHALL keep the FSM in EMIT if the merged vector is nonzero, with no done pulse.
REQ-028 Macro undefined: load_ready=0 in EMIT; loads are accepted only in IDLE.

Verification
REQ-029 Load 8'h80/8'h01, code_ready=1 -> codes 8'h0F then 8'h00 on consecutive cycles, done pulses once, count=2.
REQ-030 Load 8'h00/8'h00 -> single code 8'hF0, count=0, done pulses, return to IDLE.
REQ-031 Load 8'h24/8'h00, code_ready=0 for 5 cycles -> code holds 8'h0D, pending=16'h2400 unchanged; release -> 8'h0D, 8'h0A.
REQ-032 rst pulsed while presenting code 8'h0F -> code_valid=0, code=8'h00, pending=0 immediately, no done pulse.
REQ-033 MERGE_EN: load 16'h0003, then in the cycle index 1 transfers, merge 16'h8002 -> next codes 8'h0F, 8'h01, 8'h00, count=4.
REQ-034 No MERGE_EN: load_valid held during EMIT -> load_ready=0 and pending unaffected until IDLE.
